// File: rtl/ex_stage_fwd.sv
// ex_stage_fwd: execute stage with MEM/WB forwarding, stall/flush and an iterative multiplier
module ex_stage_fwd #(
    parameter int DATA_WIDTH    = 16,
    parameter int WIDTH         = 16,
    parameter int RF_WIDTH      = 3,
    parameter int ALU_CON_WIDTH = 3,
    parameter int MID_WIDTH     = 1,
    parameter int OFF_WIDTH     = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     validIn,
    input  logic [WIDTH-1:0]         instrIn,
    input  logic [ALU_CON_WIDTH-1:0] aluCon,
    input  logic                     operandSel,
    input  logic [OFF_WIDTH-1:0]     offset,
    input  logic [DATA_WIDTH-1:0]    operandA,
    input  logic [DATA_WIDTH-1:0]    operandB,
    input  logic [RF_WIDTH-1:0]      srcA,
    input  logic [RF_WIDTH-1:0]      srcB,
    input  logic [MID_WIDTH-1:0]     midSignalIn,
    input  logic                     memWrEn,
    input  logic                     wbWrEn,
    input  logic [RF_WIDTH-1:0]      memDst,
    input  logic [RF_WIDTH-1:0]      wbDst,
    input  logic [DATA_WIDTH-1:0]    memData,
    input  logic [DATA_WIDTH-1:0]    wbData,
    output logic [WIDTH-1:0]         instrOut,
    output logic [MID_WIDTH-1:0]     midSignalOut,
    output logic                     validOut,
    output logic [DATA_WIDTH-1:0]    aluRes,
    output logic [DATA_WIDTH-1:0]    operandBOut,
    output logic                     busy
);
    localparam int SW = $clog2(DATA_WIDTH);
    localparam int CW = $clog2(DATA_WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, next;
    logic                     valid_r, sel_r;
    logic [ALU_CON_WIDTH-1:0] con_r;
    logic [OFF_WIDTH-1:0]     off_r;
    logic [DATA_WIDTH-1:0]    a_r, b_r, fwd_a, fwd_b, b_op, alu, mcand, mplier, acc;
    logic [RF_WIDTH-1:0]      sa_r, sb_r;
    logic [CW-1:0]            cnt;
    logic                     is_mul, cap;
    assign is_mul      = con_r == ALU_CON_WIDTH'(7);
    assign busy        = (state == IDLE && valid_r && is_mul) || state == RUN;
    assign cap         = !stall && !busy;
    assign validOut    = valid_r && !busy;
    assign operandBOut = fwd_b;
    assign aluRes      = alu;
    // Operand forwarding: MEM beats WB, register 0 is never forwarded
    always_comb begin
        fwd_a = (memWrEn && memDst == sa_r && sa_r != '0) ? memData :
                (wbWrEn && wbDst == sa_r && sa_r != '0) ? wbData : a_r;
        fwd_b = (memWrEn && memDst == sb_r && sb_r != '0) ? memData :
                (wbWrEn && wbDst == sb_r && sb_r != '0) ? wbData : b_r;
        b_op  = sel_r ? DATA_WIDTH'($signed(off_r)) : fwd_b;
    end
    // ALU; MUL reports the iterative accumulator
    always_comb begin
        alu = acc;
        case (con_r)
            ALU_CON_WIDTH'(0): alu = fwd_a + b_op;
            ALU_CON_WIDTH'(1): alu = fwd_a - b_op;
            ALU_CON_WIDTH'(2): alu = fwd_a & b_op;
            ALU_CON_WIDTH'(3): alu = fwd_a | b_op;
            ALU_CON_WIDTH'(4): alu = fwd_a ^ b_op;
            ALU_CON_WIDTH'(5): alu = DATA_WIDTH'($signed(fwd_a) < $signed(b_op));
            ALU_CON_WIDTH'(6): alu = fwd_a << b_op[SW-1:0];
            default:           alu = acc;
        endcase
    end
    // Multiplier next state; flush aborts from any state
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = (valid_r && is_mul) ? RUN : IDLE;
            RUN:     next = (cnt == CW'(DATA_WIDTH - 1)) ? DONE : RUN;
            DONE:    next = stall ? DONE : IDLE;
            default: next = IDLE;
        endcase
        if (flush) next = IDLE;
    end
    // Multiplier state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end
    // Shift-add datapath: operands latched on IDLE->RUN, one step per RUN cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == IDLE && next == RUN) begin
            mcand  <= fwd_a;
            mplier <= b_op;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end
    // EX entry registers; flush forces a bubble regardless of stall/busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r      <= 1'b0;
            instrOut     <= '0;
            midSignalOut <= '0;
            con_r        <= '0;
            sel_r        <= 1'b0;
            off_r        <= '0;
            a_r          <= '0;
            b_r          <= '0;
            sa_r         <= '0;
            sb_r         <= '0;
        end else if (flush) begin
            valid_r      <= 1'b0;
            instrOut     <= '0;
            midSignalOut <= '0;
        end else if (cap) begin
            valid_r      <= validIn;
            instrOut     <= instrIn;
            midSignalOut <= midSignalIn;
            con_r        <= aluCon;
            sel_r        <= operandSel;
            off_r        <= offset;
            a_r          <= operandA;
            b_r          <= operandB;
            sa_r         <= srcA;
            sb_r         <= srcB;
        end
    end
endmodule

// File: tb/tb_ex_stage_fwd.sv
// tb_ex_stage_fwd: scoreboard bench for ex_stage_fwd with directed vectors
module tb_ex_stage_fwd;
    logic        clk = 0, reset = 1, stall = 0, flush = 0, validIn = 0;
    logic [15:0] instrIn = 0, operandA = 0, operandB = 0, memData = 0, wbData = 0;
    logic [2:0]  aluCon = 0, srcA = 0, srcB = 0, memDst = 0, wbDst = 0;
    logic        operandSel = 0, memWrEn = 0, wbWrEn = 0;
    logic [5:0]  offset = 0;
    logic [0:0]  midSignalIn = 0;
    logic [15:0] instrOut, aluRes, operandBOut;
    logic [0:0]  midSignalOut;
    logic        validOut, busy;
    int checks = 0, errors = 0;

    typedef struct packed {logic [15:0] instr; logic mid; logic [15:0] alu, opb;} exp_t;
    exp_t q[$];

    ex_stage_fwd dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .validIn(validIn),
        .instrIn(instrIn), .aluCon(aluCon), .operandSel(operandSel), .offset(offset),
        .operandA(operandA), .operandB(operandB), .srcA(srcA), .srcB(srcB),
        .midSignalIn(midSignalIn), .memWrEn(memWrEn), .wbWrEn(wbWrEn), .memDst(memDst),
        .wbDst(wbDst), .memData(memData), .wbData(wbData), .instrOut(instrOut),
        .midSignalOut(midSignalOut), .validOut(validOut), .aluRes(aluRes),
        .operandBOut(operandBOut), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare each time a new result is presented
    logic pv = 0, pc = 0;
    always @(negedge clk) begin
        if (!reset && validOut && (!pv || pc)) begin
            if (q.size() == 0) chk("unexpected_output", {16'h0, instrOut}, 32'hDEAD);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("instrOut", {16'h0, instrOut}, {16'h0, e.instr});
                chk("midSignalOut", {31'h0, midSignalOut}, {31'h0, e.mid});
                chk("aluRes", {16'h0, aluRes}, {16'h0, e.alu});
                chk("operandBOut", {16'h0, operandBOut}, {16'h0, e.opb});
            end
        end
        pv = validOut;
        pc = !stall && !busy && !reset;
    end

    // Present one instruction, wait for its capture edge, then drive its MEM/WB forwards
    task automatic iss(input logic [15:0] ins, input logic [2:0] con, input logic sel,
                       input logic [5:0] off, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] sa, input logic [2:0] sb,
                       input logic mwe, input logic [2:0] md, input logic [15:0] mdat,
                       input logic wwe, input logic [2:0] wd, input logic [15:0] wdat,
                       input logic push, input logic [15:0] ea, input logic [15:0] eb);
        int n = 0;
        validIn = 1; instrIn = ins; midSignalIn = ins[0]; aluCon = con; operandSel = sel;
        offset = off; operandA = a; operandB = b; srcA = sa; srcB = sb;
        while ((busy || stall) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) chk("capture_timeout", 32'(n), 0);
        if (push) q.push_back({ins, ins[0], ea, eb});
        @(posedge clk); #1;
        memWrEn = mwe; memDst = md; memData = mdat; wbWrEn = wwe; wbDst = wd; wbData = wdat;
        validIn = 0;
    endtask

    initial begin
        int n;
        #12;
        chk("rst_instrOut", {16'h0, instrOut}, 0);
        chk("rst_validOut", {31'h0, validOut}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_aluRes", {16'h0, aluRes}, 0);
        chk("rst_midSignalOut", {31'h0, midSignalOut}, 0);
        @(posedge clk); #1; reset = 0;
        iss(16'h1001, 0, 0, 0, 16'h7777, 16'h0005, 3, 0, 1, 3, 16'h0010, 0, 0, 0, 1, 16'h0015, 16'h0005);
        iss(16'h1002, 0, 0, 0, 16'h7777, 16'h0005, 3, 0, 1, 3, 16'h0010, 1, 3, 16'h0100, 1, 16'h0015, 16'h0005);
        iss(16'h1003, 0, 0, 0, 16'h0002, 16'h0005, 0, 0, 1, 0, 16'h0010, 1, 0, 16'h0100, 1, 16'h0007, 16'h0005);
        iss(16'h1004, 1, 0, 0, 16'h0003, 16'h4444, 0, 2, 0, 0, 0, 1, 2, 16'h0009, 1, 16'hFFFA, 16'h0009);
        iss(16'h1005, 0, 1, 6'h3E, 16'h0004, 16'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0002, 16'h1234);
        iss(16'h1006, 2, 0, 0, 16'hF0F0, 16'h3C3C, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h3030, 16'h3C3C);
        iss(16'h1007, 3, 0, 0, 16'hF0F0, 16'h3C3C, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFCFC, 16'h3C3C);
        iss(16'h1008, 4, 0, 0, 16'hF0F0, 16'h3C3C, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hCCCC, 16'h3C3C);
        iss(16'h1009, 5, 0, 0, 16'h8000, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0001, 16'h0001);
        iss(16'h100A, 5, 0, 0, 16'h0001, 16'h8000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h8000);
        iss(16'h100B, 6, 0, 0, 16'h0003, 16'h0014, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0030, 16'h0014);
        iss(16'h100C, 0, 0, 0, 16'hFFFF, 16'h0002, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0001, 16'h0002);
        iss(16'h100D, 7, 0, 0, 16'h0123, 16'h0045, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h4E6F, 16'h0045);
        n = 0;
        while (busy && n < 100) begin
            n++; @(posedge clk); #1;
        end
        chk("mul_busy_cycles", 32'(n), 17);
        chk("mul_validOut", {31'h0, validOut}, 1);
        iss(16'h100E, 7, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0001, 16'hFFFF);
        iss(16'h100F, 7, 0, 0, 16'h5555, 16'h0007, 1, 0, 1, 1, 16'h0003, 0, 0, 0, 1, 16'h0015, 16'h0007);
        iss(16'h1010, 0, 0, 0, 16'h0100, 16'h0011, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0111, 16'h0011);
        stall = 1;
        repeat (3) begin
            @(posedge clk); #1;
            operandA = ~operandA;
            chk("stall_instrOut", {16'h0, instrOut}, 32'h1010);
            chk("stall_aluRes", {16'h0, aluRes}, 32'h0111);
        end
        stall = 0;
        iss(16'h1011, 7, 0, 0, 16'h0123, 16'h0045, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("run_busy", {31'h0, busy}, 1);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("flush_busy", {31'h0, busy}, 0);
        chk("flush_validOut", {31'h0, validOut}, 0);
        chk("flush_instrOut", {16'h0, instrOut}, 0);
        iss(16'h1012, 0, 0, 0, 16'h0001, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0002, 16'h0001);
        iss(16'h1013, 7, 0, 0, 16'h0123, 16'h0045, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) @(posedge clk);
        #2;
        reset = 1;
        #1;
        chk("arst_busy", {31'h0, busy}, 0);
        chk("arst_validOut", {31'h0, validOut}, 0);
        chk("arst_instrOut", {16'h0, instrOut}, 0);
        @(posedge clk); #1;
        reset = 0;
        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
